rr_grant_arbiter: RTL and testbench

//   Shares one downstream resource among 8 requesters. Arbitration uses

---
 rtl/arb_pkg.sv | 13 +
 rtl/prio_enc8.sv | 26 ++
 rtl/rr_grant_arbiter.sv | 110 +++++++++++
 tb/tb_rr_grant_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and sizes for the round-robin grant arbiter.
// Imported by the arbiter top and its priority encoder.
package arb_pkg;

    localparam int NREQ = 8;
    localparam int ID_W = 3;

    typedef enum logic {
        ST_IDLE,
        ST_GRANT
    } state_t;

endpackage

// File: rtl/prio_enc8.sv
// Highest-index-first priority encoder over the 8 request lines.
// Gated by en so a disabled arbiter never reports a candidate.
module prio_enc8
    import arb_pkg::*;
(
    input  logic            en,
    input  logic [NREQ-1:0] vec,
    output logic [ID_W-1:0] idx,
    output logic            any
);

    always_comb begin
        idx = '0;
        any = 1'b0;
        if (en) begin
            // Ascending scan: the last set bit seen is the highest.
            for (int i = 0; i < NREQ; i++) begin
                if (vec[i]) begin
                    idx = ID_W'(i);
                    any = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter granting one of 8 requesters a shared resource,
// with release on done, request drop, disable or hold limit.
module rr_grant_arbiter
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [NREQ-1:0] req,
    input  logic            done,
    output logic [NREQ-1:0] gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            gnt_valid,
    output logic            timeout
);

    state_t           state, state_n;
    logic [CNT_W-1:0] hold_cnt, cnt_n;
    logic [ID_W-1:0]  last_id, last_n;
    logic [NREQ-1:0]  gnt_n;
    logic [ID_W-1:0]  id_n;
    logic             valid_n;
    logic             to_n;

    logic [NREQ-1:0]  mask;
    logic [NREQ-1:0]  masked;
    logic [ID_W-1:0]  m_idx, r_idx, win;
    logic             m_any, r_any;
    logic             early_rel;
    logic             at_limit;

    // Requesters below the previous winner get the next turn.
    assign mask   = (NREQ'(1) << last_id) - NREQ'(1);
    assign masked = req & mask;

    prio_enc8 u_enc_masked (
        .en  (en),
        .vec (masked),
        .idx (m_idx),
        .any (m_any)
    );

    prio_enc8 u_enc_raw (
        .en  (en),
        .vec (req),
        .idx (r_idx),
        .any (r_any)
    );

    assign win       = m_any ? m_idx : r_idx;
    assign early_rel = done || !req[gnt_id] || !en;
    assign at_limit  = (hold_cnt == CNT_W'(MAX_HOLD - 1));

    always_comb begin
        state_n = state;
        cnt_n   = hold_cnt;
        last_n  = last_id;
        gnt_n   = gnt;
        id_n    = gnt_id;
        valid_n = gnt_valid;
        to_n    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (r_any) begin
                    state_n = ST_GRANT;
                    cnt_n   = '0;
                    last_n  = win;
                    gnt_n   = NREQ'(1) << win;
                    id_n    = win;
                    valid_n = 1'b1;
                end
            end
            ST_GRANT: begin
                cnt_n = hold_cnt + CNT_W'(1);
                if (early_rel || at_limit) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    gnt_n   = '0;
                    valid_n = 1'b0;
                    to_n    = at_limit && !early_rel;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            hold_cnt  <= '0;
            last_id   <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_n;
            hold_cnt  <= cnt_n;
            last_id   <= last_n;
            gnt       <= gnt_n;
            gnt_id    <= id_n;
            gnt_valid <= valid_n;
            timeout   <= to_n;
        end
    end

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Bench for rr_grant_arbiter: directed scenarios plus random traffic
// checked every cycle against a turn-taking reference model.
module tb_rr_grant_arbiter;

    localparam int MAX_HOLD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int n_chk  = 0;
    int n_fail = 0;

    int         m_owner;
    int         m_last;
    int         m_held;
    logic [2:0] m_gid;
    logic       m_to;

    rr_grant_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    a_onehot: assert property (@(posedge clk) $onehot0(gnt));

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Next turn goes to the highest requester below the last winner,
    // otherwise to the highest requester overall.
    function automatic int pick(input logic [7:0] r, input int last);
        for (int i = last - 1; i >= 0; i--)
            if (r[i]) return i;
        for (int i = 7; i >= 0; i--)
            if (r[i]) return i;
        return -1;
    endfunction

    task automatic model_step();
        int w;
        if (rst) begin
            m_owner = -1;
            m_last  = 0;
            m_held  = 0;
            m_gid   = 3'd0;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            w = pick(req, m_last);
            if (en && w >= 0) begin
                m_owner = w;
                m_last  = w;
                m_gid   = 3'(w);
                m_held  = 1;
            end
        end else if (done || !req[m_owner] || !en) begin
            m_owner = -1;
            m_to    = 1'b0;
        end else if (m_held == MAX_HOLD) begin
            m_owner = -1;
            m_to    = 1'b1;
        end else begin
            m_held++;
            m_to = 1'b0;
        end
    endtask

    task automatic step();
        logic [7:0] eg;
        @(posedge clk);
        model_step();
        #1;
        eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        chk("gnt", 32'(gnt), 32'(eg));
        chk("gnt_id", 32'(gnt_id), 32'(m_gid));
        chk("gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("invariant", 32'(gnt), 32'(8'({7'd0, gnt_valid} << gnt_id)));
    endtask

    initial begin
        m_owner = -1;
        m_last  = 0;
        m_held  = 0;
        m_gid   = 3'd0;
        m_to    = 1'b0;
        rst  = 1'b1;
        en   = 1'b0;
        req  = 8'h00;
        done = 1'b0;
        step();
        chk("rst_gnt", 32'(gnt), 32'h0);

        // T1: fixed priority then rotation to the lower requester
        rst = 1'b0; en = 1'b1; req = 8'h81;
        step();
        chk("t1_first", 32'(gnt), 32'h80);
        done = 1'b1; step();
        chk("t1_rel", 32'(gnt), 32'h00);
        done = 1'b0; step();
        chk("t1_second", 32'(gnt), 32'h01);
        done = 1'b1; step();
        done = 1'b0;

        // T2: full rotation with one idle cycle per handover
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("t2_order", 32'(gnt_id), 32'((15 - k) % 8));
            done = 1'b1; step();
            chk("t2_gap", 32'(gnt_valid), 32'h0);
            done = 1'b0;
        end

        // T3: lone requester runs into the hold limit
        rst = 1'b1; step(); rst = 1'b0;
        req = 8'h10;
        step();
        for (int k = 1; k < MAX_HOLD; k++) step();
        chk("t3_held", 32'(gnt), 32'h10);
        step();
        chk("t3_timeout", 32'(timeout), 32'h1);
        chk("t3_rel", 32'(gnt), 32'h00);
        step();
        chk("t3_regrant", 32'(gnt), 32'h10);
        chk("t3_pulse", 32'(timeout), 32'h0);

        // T4: owner drops its request
        rst = 1'b1; step(); rst = 1'b0;
        req = 8'h20; step();
        chk("t4_id", 32'(gnt_id), 32'd5);
        req = 8'h00; step();
        chk("t4_rel", 32'(gnt), 32'h00);
        chk("t4_noto", 32'(timeout), 32'h0);

        // T5: disable aborts and blocks grants
        req = 8'hFF; step();
        en = 1'b0; step();
        chk("t5_abort", 32'(gnt), 32'h00);
        for (int k = 0; k < 5; k++) step();
        chk("t5_blocked", 32'(gnt_valid), 32'h0);
        en = 1'b1;

        // T6: reset mid-grant restores fixed priority
        rst = 1'b1; step(); rst = 1'b0;
        req = 8'h04; step();
        chk("t6_grant", 32'(gnt), 32'h04);
        rst = 1'b1; step();
        chk("t6_rst", 32'(gnt), 32'h00);
        rst = 1'b0; req = 8'h06; step();
        chk("t6_fixed", 32'(gnt), 32'h04);

        // Random traffic against the model
        for (int k = 0; k < 4000; k++) begin
            rst  = ($urandom % 250) == 0;
            en   = ($urandom % 20) != 0;
            done = ($urandom % 10) == 0;
            if (($urandom % 5) == 0)
                req = 8'($urandom);
            else if (($urandom % 40) == 0)
                req = 8'(1 << ($urandom % 8));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
